// File: rtl/elevator_dispatcher.sv
// Four-floor elevator dispatcher: latches floor calls, steers the car with stop_go/up_down, times door stops.
// Optional move watchdog enabled by defining MOVE_WDOG_EN.
module elevator_dispatcher #(
  parameter int DOOR_CYCLES = 8,
  parameter int WDOG_CYCLES = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       call_valid,
  input  logic [1:0] call_floor,
  output logic       call_ready,
  input  logic [2:0] current_floor,
  output logic       stop_go,
  output logic       up_down,
  output logic       door_open,
  output logic       served_valid,
  output logic [1:0] served_floor,
  output logic       fault
);

  typedef enum logic [2:0] {S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_DOOR, S_FAULT} state_t;

  state_t     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic       dir_q, dir_d;
  logic [7:0] door_cnt_q, door_cnt_d;
  logic       stop_go_q, stop_go_d, up_down_q, up_down_d, door_open_q, door_open_d;
  logic       served_valid_q, served_valid_d, fault_q, fault_d, call_ready_q, call_ready_d;
  logic [1:0] served_floor_q, served_floor_d;

`ifdef MOVE_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_q, wdog_d;
  logic [2:0]    cf_prev_q;
`endif

  function automatic logic [3:0] above_mask(input logic [1:0] f);
    return 4'b1110 << f;
  endfunction

  function automatic logic [3:0] below_mask(input logic [1:0] f);
    return (4'b0001 << f) - 4'd1;
  endfunction

  logic [1:0] cf;
  logic       legal, acc, absorb;
  logic [3:0] pend_v;
  logic       here_above, here_below, door_above, door_below;
  logic       go_door, go_up, go_down, go_idle;

  always_comb begin
    cf         = current_floor[1:0];
    legal      = !current_floor[2];
    acc        = call_valid && call_ready_q;
    // While the door is open, a call for the floor being served is simply absorbed.
    absorb     = (state_q == S_DOOR) && (call_floor == served_floor_q);
    pend_v     = pending_q | ((acc && !absorb) ? (4'b0001 << call_floor) : 4'b0000);
    here_above = |(pend_v & above_mask(cf));
    here_below = |(pend_v & below_mask(cf));
    door_above = |(pend_v & above_mask(served_floor_q));
    door_below = |(pend_v & below_mask(served_floor_q));

    state_d        = state_q;
    pending_d      = pend_v;
    dir_d          = dir_q;
    door_cnt_d     = door_cnt_q;
    stop_go_d      = stop_go_q;
    up_down_d      = up_down_q;
    door_open_d    = 1'b0;
    served_valid_d = 1'b0;
    served_floor_d = served_floor_q;
    fault_d        = fault_q;
    go_door        = 1'b0;
    go_up          = 1'b0;
    go_down        = 1'b0;
    go_idle        = 1'b0;

    case (state_q)
      S_IDLE: if (legal) begin
        if (pend_v[cf])                    go_door = 1'b1;
        else if (here_above && here_below) begin
          go_up   = dir_q;
          go_down = !dir_q;
        end
        else if (here_above)               go_up   = 1'b1;
        else if (here_below)               go_down = 1'b1;
      end
      S_MOVE_UP: if (legal) begin
        if (pend_v[cf])       go_door = 1'b1;
        else if (cf == 2'd3)  go_idle = 1'b1;
      end
      S_MOVE_DOWN: if (legal) begin
        if (pend_v[cf])       go_door = 1'b1;
        else if (cf == 2'd0)  go_idle = 1'b1;
      end
      S_DOOR: begin
        door_open_d = 1'b1;
        if (door_cnt_q != 8'd0) door_cnt_d = door_cnt_q - 8'd1;
        else if (dir_q ? door_above : door_below) begin
          go_up   = dir_q;
          go_down = !dir_q;
        end
        else if (dir_q ? door_below : door_above) begin
          go_up   = !dir_q;
          go_down = dir_q;
        end
        else go_idle = 1'b1;
      end
      S_FAULT: begin
        pending_d   = 4'b0000;
        stop_go_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (go_door) begin
      state_d          = S_DOOR;
      pending_d        = pend_v & ~(4'b0001 << cf);
      served_valid_d   = 1'b1;
      served_floor_d   = cf;
      door_cnt_d       = 8'(DOOR_CYCLES - 1);
      stop_go_d        = 1'b0;
      door_open_d      = 1'b1;
    end
    if (go_up) begin
      state_d     = S_MOVE_UP;
      stop_go_d   = 1'b1;
      up_down_d   = 1'b1;
      dir_d       = 1'b1;
      door_open_d = 1'b0;
    end
    if (go_down) begin
      state_d     = S_MOVE_DOWN;
      stop_go_d   = 1'b1;
      up_down_d   = 1'b0;
      dir_d       = 1'b0;
      door_open_d = 1'b0;
    end
    if (go_idle) begin
      state_d     = S_IDLE;
      stop_go_d   = 1'b0;
      door_open_d = 1'b0;
    end

`ifdef MOVE_WDOG_EN
    // Count cycles spent moving without the car reporting a new floor.
    wdog_d = '0;
    if ((state_q == S_MOVE_UP || state_q == S_MOVE_DOWN) && state_d == state_q) begin
      wdog_d = (current_floor != cf_prev_q) ? '0 : wdog_q + 1'b1;
      if (wdog_d == WW'(WDOG_CYCLES)) begin
        state_d     = S_FAULT;
        stop_go_d   = 1'b0;
        door_open_d = 1'b0;
        fault_d     = 1'b1;
        pending_d   = 4'b0000;
        wdog_d      = '0;
      end
    end
`endif

    call_ready_d = (state_d != S_FAULT);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q        <= S_IDLE;
      pending_q      <= 4'b0000;
      dir_q          <= 1'b1;
      door_cnt_q     <= 8'd0;
      stop_go_q      <= 1'b0;
      up_down_q      <= 1'b0;
      door_open_q    <= 1'b0;
      served_valid_q <= 1'b0;
      served_floor_q <= 2'd0;
      fault_q        <= 1'b0;
      call_ready_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      dir_q          <= dir_d;
      door_cnt_q     <= door_cnt_d;
      stop_go_q      <= stop_go_d;
      up_down_q      <= up_down_d;
      door_open_q    <= door_open_d;
      served_valid_q <= served_valid_d;
      served_floor_q <= served_floor_d;
      fault_q        <= fault_d;
      call_ready_q   <= call_ready_d;
    end
  end

`ifdef MOVE_WDOG_EN
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wdog_q    <= '0;
      cf_prev_q <= 3'd0;
    end else begin
      wdog_q    <= wdog_d;
      cf_prev_q <= current_floor;
    end
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign call_ready   = call_ready_q;
  assign stop_go      = stop_go_q;
  assign up_down      = up_down_q;
  assign door_open    = door_open_q;
  assign served_valid = served_valid_q;
  assign served_floor = served_floor_q;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Bench for elevator_dispatcher: a simple car model moves one floor every 3 cycles while stop_go is high;
// expected served floors are queued when calls are issued and popped on each served pulse.
module tb_elevator_dispatcher;

  logic       CLK, RST, call_valid, call_ready;
  logic [1:0] call_floor, served_floor;
  logic [2:0] floor;
  logic       stop_go, up_down, door_open, served_valid, fault;

  int n_chk = 0, n_fail = 0;
  int exp_q[$];
  int door_len = 0, mv = 0;
  bit plant_en = 1;

  elevator_dispatcher #(.DOOR_CYCLES(8), .WDOG_CYCLES(64)) dut (
    .CLK(CLK), .RST(RST), .call_valid(call_valid), .call_floor(call_floor),
    .call_ready(call_ready), .current_floor(floor), .stop_go(stop_go), .up_down(up_down),
    .door_open(door_open), .served_valid(served_valid), .served_floor(served_floor), .fault(fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
    chk("excl", 32'(stop_go & door_open), 0);
    if (served_valid) begin
      chk("served_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("served_floor", 32'(served_floor), exp_q.pop_front());
    end
    if (door_open) door_len++;
    else if (door_len != 0) begin
      chk("door_len", door_len, 8);
      door_len = 0;
    end
    if (plant_en && stop_go) begin
      mv++;
      if (mv == 3) begin
        mv = 0;
        floor = up_down ? floor + 3'd1 : floor - 3'd1;
      end
    end else mv = 0;
  endtask

  task automatic call(input logic [1:0] f);
    call_valid = 1'b1;
    call_floor = f;
    tick();
    call_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!stop_go && !door_open && exp_q.size() == 0 && door_len == 0) begin
        done = 1;
        break;
      end
    end
    chk(tag, 32'(done), 1);
  endtask

  initial begin
    bit done;
    RST = 1'b0; call_valid = 1'b1; call_floor = 2'd3; floor = 3'd0;
    repeat (3) tick();
    chk("rst_stop_go", 32'(stop_go), 0);
    chk("rst_up_down", 32'(up_down), 0);
    chk("rst_door", 32'(door_open), 0);
    chk("rst_served", {served_valid, served_floor}, 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_ready", 32'(call_ready), 1);
    call_valid = 1'b0;
    RST = 1'b1;
    repeat (3) tick();
    chk("rst_call_dropped", 32'(stop_go), 0);

    // Single trip 0 -> 2
    exp_q.push_back(2);
    call(2'd2);
    chk("s1_go", {stop_go, up_down}, 2'b11);
    wait_idle("s1_idle");
    chk("s1_floor", floor, 2);

    // Back to 0, then calls 1 and 3 back-to-back
    exp_q.push_back(0);
    call(2'd0);
    chk("s2_down", {stop_go, up_down}, 2'b10);
    wait_idle("s2a_idle");
    exp_q.push_back(1);
    exp_q.push_back(3);
    call(2'd1);
    call(2'd3);
    wait_idle("s2_idle");
    chk("s2_floor", floor, 3);

    // Go to 1, then up toward 3 with a late call for 0
    exp_q.push_back(1);
    call(2'd1);
    wait_idle("s3a_idle");
    exp_q.push_back(3);
    exp_q.push_back(0);
    call(2'd3);
    done = 0;
    for (int i = 0; i < 50; i++) begin
      if (floor == 3'd2) begin done = 1; break; end
      tick();
    end
    chk("s3_reach2", 32'(done), 1);
    call(2'd0);
    done = 0;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 1) begin done = 1; break; end
      tick();
    end
    chk("s3_served3", 32'(done), 1);
    done = 0;
    for (int i = 0; i < 50; i++) begin
      if (stop_go) begin done = 1; break; end
      tick();
    end
    chk("s3_moving", 32'(done), 1);
    chk("s3_reverse", 32'(up_down), 0);
    wait_idle("s3_idle");
    chk("s3_floor", floor, 0);

    // Call at the current floor, repeated during the door
    exp_q.push_back(0);
    call(2'd0);
    chk("s4_door", {stop_go, door_open}, 2'b01);
    call(2'd0);
    repeat (2) tick();
    call(2'd0);
    wait_idle("s4_idle");

    // Invalid floor code holds the car's command
    plant_en = 0;
    exp_q.push_back(2);
    call(2'd2);
    floor = 3'd5;
    repeat (4) tick();
    chk("s5_hold", {stop_go, up_down, door_open}, 3'b110);
    floor = 3'd2;
    tick();
    chk("s5_door", {stop_go, door_open}, 2'b01);
    plant_en = 1;
    wait_idle("s5_idle");

    // Reset while moving
    call(2'd0);
    tick();
    chk("s6_moving", 32'(stop_go), 1);
    RST = 1'b0;
    tick();
    chk("s6_rst", {stop_go, up_down, door_open, served_valid, call_ready}, 5'b00001);
    RST = 1'b1;
    repeat (5) tick();
    chk("s6_pending_empty", {stop_go, door_open}, 0);

    // Car stuck at floor 0 while commanded up
    plant_en = 0;
    floor = 3'd0;
    tick();
    call(2'd3);
`ifdef MOVE_WDOG_EN
    repeat (63) tick();
    chk("wd_not_yet", 32'(fault), 0);
    tick();
    chk("wd_fault", {fault, stop_go, door_open, call_ready}, 4'b1000);
`else
    repeat (64) tick();
    chk("wd_absent", {fault, stop_go}, 2'b01);
`endif
    RST = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    chk("end_ready", 32'(call_ready), 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
